plic_claim_ctrl: RTL and testbench

APB4 master that services PLIC interrupt targets on behalf of a simple handler. When the PLIC raises `irq` for its target, the block reads the target's claim register, hands the claimed source ID to a handler over a valid/ready port, and waits for the handler's done pulse. It then writes the same ID back to the claim/complete register. It sits between the PLIC's APB4 slave port and a hardware interrupt handler (DMA kick, mailbox, etc.) that has no CPU of its own.

---
 rtl/plic_claim_ctrl.sv | 157 +++++++++++++++
 tb/tb_plic_claim_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/plic_claim_ctrl.sv
// plic_claim_ctrl: APB4 master that claims a PLIC interrupt, hands the ID to a hardware handler, then completes it.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   enable, irq        accept new interrupts, PLIC interrupt request for target 0
//   PSEL..PWDATA       APB4 master request (registered outputs)
//   PRDATA..PSLVERR    APB4 slave response
//   int_valid, int_id  claimed ID offered to the handler
//   int_ready          handler accepts the ID
//   int_done           handler finished (single-cycle pulse)
//   busy               sequence in progress
//   err                sticky APB error flag
//   spurious_cnt       saturating count of claims that returned ID 0
module plic_claim_ctrl #(
    parameter int          PADDR_SIZE   = 32,
    parameter int          PDATA_SIZE   = 32,
    parameter logic [31:0] BASE         = 32'h1000_0000,
    parameter logic [31:0] CLAIM_OFFSET = 32'h0020_0004,
    parameter int          SOURCES_BITS = 4,
    parameter int          HOLDOFF      = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    irq,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic                    PWRITE,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR,
    output logic                    int_valid,
    output logic [SOURCES_BITS-1:0] int_id,
    input  logic                    int_ready,
    input  logic                    int_done,
    output logic                    busy,
    output logic                    err,
    output logic [7:0]              spurious_cnt
);
    localparam logic [PADDR_SIZE-1:0] CLAIM_ADDR = PADDR_SIZE'(BASE + CLAIM_OFFSET);
    localparam logic [3:0]            HOLD_INIT  = 4'(HOLDOFF);

    typedef enum logic [2:0] {
        IDLE, RD_SETUP, RD_ACCESS, DISPATCH, SERVICE, WR_SETUP, WR_ACCESS, HOLD
    } state_t;

    state_t                  state_q;
    logic [3:0]              hold_q;
    logic                    psel_q, penable_q, pwrite_q;
    logic [PADDR_SIZE-1:0]   paddr_q;
    logic [PDATA_SIZE/8-1:0] pstrb_q;
    logic [PDATA_SIZE-1:0]   pwdata_q;
    logic                    int_valid_q;
    logic [SOURCES_BITS-1:0] int_id_q;
    logic                    err_q;
    logic [7:0]              spur_q;

    logic [SOURCES_BITS-1:0] rd_id;
    logic                    wr_start;
    logic                    unused_prdata;

    assign rd_id         = PRDATA[SOURCES_BITS-1:0];
    assign unused_prdata = ^PRDATA[PDATA_SIZE-1:SOURCES_BITS];
    // Completion starts either straight from DISPATCH (ready and done together) or from SERVICE.
    assign wr_start = (state_q == DISPATCH && int_ready && int_done) || (state_q == SERVICE && int_done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pstrb_q     <= '0;
            pwdata_q    <= '0;
            int_valid_q <= 1'b0;
            int_id_q    <= '0;
            err_q       <= 1'b0;
            spur_q      <= '0;
        end else begin
            case (state_q)
                IDLE: if (enable && irq) begin
                    state_q <= RD_SETUP;
                    psel_q  <= 1'b1;
                    paddr_q <= CLAIM_ADDR;
                end
                RD_SETUP: begin
                    state_q   <= RD_ACCESS;
                    penable_q <= 1'b1;
                end
                RD_ACCESS: if (PREADY) begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    paddr_q   <= '0;
                    if (PSLVERR) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else if (rd_id == '0) begin
                        if (spur_q != 8'hFF) spur_q <= spur_q + 8'd1;
                        hold_q  <= HOLD_INIT;
                        state_q <= HOLD;
                    end else begin
                        int_id_q    <= rd_id;
                        int_valid_q <= 1'b1;
                        state_q     <= DISPATCH;
                    end
                end
                DISPATCH: if (int_ready) begin
                    int_valid_q <= 1'b0;
                    state_q     <= SERVICE;
                end
                WR_SETUP: begin
                    state_q   <= WR_ACCESS;
                    penable_q <= 1'b1;
                end
                WR_ACCESS: if (PREADY) begin
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                    pwrite_q  <= 1'b0;
                    paddr_q   <= '0;
                    pstrb_q   <= '0;
                    pwdata_q  <= '0;
                    if (PSLVERR) err_q <= 1'b1;
                    hold_q    <= HOLD_INIT;
                    state_q   <= HOLD;
                end
                HOLD: if (hold_q == '0) state_q <= IDLE;
                      else hold_q <= hold_q - 4'd1;
                default: ;
            endcase
            // Overrides the DISPATCH/SERVICE arms above when the handler reports done.
            if (wr_start) begin
                state_q  <= WR_SETUP;
                psel_q   <= 1'b1;
                pwrite_q <= 1'b1;
                paddr_q  <= CLAIM_ADDR;
                pstrb_q  <= '1;
                pwdata_q <= PDATA_SIZE'(int_id_q);
            end
        end
    end

    assign PSEL         = psel_q;
    assign PENABLE      = penable_q;
    assign PADDR        = paddr_q;
    assign PWRITE       = pwrite_q;
    assign PSTRB        = pstrb_q;
    assign PWDATA       = pwdata_q;
    assign int_valid    = int_valid_q;
    assign int_id       = int_id_q;
    assign busy         = state_q != IDLE;
    assign err          = err_q;
    assign spurious_cnt = spur_q;
endmodule

// File: tb/tb_plic_claim_ctrl.sv
// tb_plic_claim_ctrl: directed scenario bench for plic_claim_ctrl.
module tb_plic_claim_ctrl;
    logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, irq = 1'b0;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b1, PSLVERR = 1'b0, int_ready = 1'b0, int_done = 1'b0;
    logic        PSEL, PENABLE, PWRITE, int_valid, busy, err;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB, int_id;
    logic [7:0]  spurious_cnt;
    int compared = 0, mismatched = 0, wr_cnt = 0;

    localparam logic [31:0] ADDR = 32'h1020_0004;

    plic_claim_ctrl dut (
        .clk(clk), .rst(rst), .enable(enable), .irq(irq),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PSTRB(PSTRB), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .int_valid(int_valid), .int_id(int_id), .int_ready(int_ready), .int_done(int_done),
        .busy(busy), .err(err), .spurious_cnt(spurious_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (!rst && PSEL && PENABLE && PWRITE && PREADY) wr_cnt <= wr_cnt + 1;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b1;
        step; step;
        rst = 1'b0;
        compared++; if ({PSEL, PENABLE, PWRITE, int_valid, busy, err} !== 6'b0) begin mismatched++; $display("FAIL reset_ctl got=%b want=000000", {PSEL, PENABLE, PWRITE, int_valid, busy, err}); end
        compared++; if ({PADDR, PWDATA, PSTRB} !== 68'h0) begin mismatched++; $display("FAIL reset_bus got=%h/%h/%h want=0", PADDR, PWDATA, PSTRB); end
        compared++; if ({int_id, spurious_cnt} !== 12'h0) begin mismatched++; $display("FAIL reset_id_cnt got=%h/%h want=0", int_id, spurious_cnt); end
    endtask

    task automatic test_basic;
        int w0;
        w0 = wr_cnt;
        PRDATA = 32'h5; PREADY = 1'b1; int_ready = 1'b1; irq = 1'b1;
        step;
        irq = 1'b0;
        compared++; if ({PSEL, PENABLE, PWRITE, int_valid, busy} !== 5'b10001) begin mismatched++; $display("FAIL basic_rd_setup got=%b want=10001", {PSEL, PENABLE, PWRITE, int_valid, busy}); end
        compared++; if (PADDR !== ADDR || PSTRB !== 4'h0) begin mismatched++; $display("FAIL basic_rd_addr got=%h/%h want=%h/0", PADDR, PSTRB, ADDR); end
        step;
        compared++; if ({PSEL, PENABLE, PWRITE} !== 3'b110 || PADDR !== ADDR) begin mismatched++; $display("FAIL basic_rd_access got=%b/%h want=110/%h", {PSEL, PENABLE, PWRITE}, PADDR, ADDR); end
        step;
        compared++; if ({int_valid, PSEL} !== 2'b10 || int_id !== 4'd5) begin mismatched++; $display("FAIL basic_dispatch got=%b id=%0d want=10 id=5", {int_valid, PSEL}, int_id); end
        step;
        compared++; if ({int_valid, busy} !== 2'b01) begin mismatched++; $display("FAIL basic_service got=%b want=01", {int_valid, busy}); end
        step; step;
        int_done = 1'b1;
        step;
        int_done = 1'b0;
        compared++; if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PWDATA !== 32'h5 || PSTRB !== 4'hF || PADDR !== ADDR) begin mismatched++; $display("FAIL basic_wr_setup got=%b %h %h %h", {PSEL, PENABLE, PWRITE}, PWDATA, PSTRB, PADDR); end
        step;
        compared++; if ({PSEL, PENABLE, PWRITE} !== 3'b111 || PWDATA !== 32'h5 || int_id !== 4'd5) begin mismatched++; $display("FAIL basic_wr_access got=%b %h id=%0d", {PSEL, PENABLE, PWRITE}, PWDATA, int_id); end
        step;
        compared++; if ({PSEL, busy} !== 2'b01 || PWDATA !== 32'h0) begin mismatched++; $display("FAIL basic_hold_entry got=%b %h want=01 0", {PSEL, busy}, PWDATA); end
        step; step;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL basic_hold_3rd got=%b want=1", busy); end
        step;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL basic_idle got=%b want=0", busy); end
        compared++; if (wr_cnt !== w0 + 1) begin mismatched++; $display("FAIL basic_wr_count got=%0d want=%0d", wr_cnt, w0 + 1); end
    endtask

    task automatic test_spurious;
        int w0;
        w0 = wr_cnt;
        PRDATA = 32'h0; PREADY = 1'b1; irq = 1'b1;
        step;
        irq = 1'b0;
        step; step;
        compared++; if (spurious_cnt !== 8'd1 || {int_valid, PSEL, busy} !== 3'b001) begin mismatched++; $display("FAIL spur_first got=%0d %b want=1 001", spurious_cnt, {int_valid, PSEL, busy}); end
        step; step; step;
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL spur_idle got=%b want=0", busy); end
        for (int i = 0; i < 254; i++) begin
            irq = 1'b1;
            step;
            irq = 1'b0;
            repeat (5) step;
        end
        compared++; if (spurious_cnt !== 8'd255) begin mismatched++; $display("FAIL spur_255 got=%0d want=255", spurious_cnt); end
        irq = 1'b1;
        step;
        irq = 1'b0;
        repeat (5) step;
        compared++; if (spurious_cnt !== 8'd255) begin mismatched++; $display("FAIL spur_saturate got=%0d want=255", spurious_cnt); end
        compared++; if (wr_cnt !== w0) begin mismatched++; $display("FAIL spur_no_write got=%0d want=%0d", wr_cnt, w0); end
    endtask

    task automatic test_wait_states;
        int w0;
        w0 = wr_cnt;
        PRDATA = 32'h1234_5675; PREADY = 1'b0; int_ready = 1'b1; irq = 1'b1;
        step;
        irq = 1'b0;
        step;
        for (int i = 0; i < 3; i++) begin
            step;
            compared++; if ({PSEL, PENABLE, PWRITE, int_valid} !== 4'b1100 || PADDR !== ADDR) begin mismatched++; $display("FAIL ws_rd_stall%0d got=%b %h", i, {PSEL, PENABLE, PWRITE, int_valid}, PADDR); end
        end
        PREADY = 1'b1;
        step;
        compared++; if (int_valid !== 1'b1 || int_id !== 4'd5) begin mismatched++; $display("FAIL ws_dispatch got=%b id=%0d want=1 id=5", int_valid, int_id); end
        step;
        int_done = 1'b1;
        step;
        int_done = 1'b0; PREADY = 1'b0;
        step;
        for (int i = 0; i < 3; i++) begin
            step;
            compared++; if ({PSEL, PENABLE, PWRITE} !== 3'b111 || PWDATA !== 32'h5 || PADDR !== ADDR || int_id !== 4'd5) begin mismatched++; $display("FAIL ws_wr_stall%0d got=%b %h %h id=%0d", i, {PSEL, PENABLE, PWRITE}, PWDATA, PADDR, int_id); end
        end
        PREADY = 1'b1;
        step;
        compared++; if (PSEL !== 1'b0) begin mismatched++; $display("FAIL ws_hold got=%b want=0", PSEL); end
        step; step; step;
        compared++; if (busy !== 1'b0 || wr_cnt !== w0 + 1) begin mismatched++; $display("FAIL ws_once got busy=%b wr=%0d want 0 %0d", busy, wr_cnt, w0 + 1); end
    endtask

    task automatic test_same_cycle;
        int w0;
        w0 = wr_cnt;
        PRDATA = 32'h9; PREADY = 1'b1; int_ready = 1'b0; irq = 1'b1;
        step;
        irq = 1'b0;
        step; step;
        compared++; if (int_valid !== 1'b1 || int_id !== 4'd9) begin mismatched++; $display("FAIL sc_dispatch got=%b id=%0d want=1 id=9", int_valid, int_id); end
        step;
        compared++; if (int_valid !== 1'b1) begin mismatched++; $display("FAIL sc_wait_ready got=%b want=1", int_valid); end
        int_ready = 1'b1; int_done = 1'b1;
        step;
        int_ready = 1'b0; int_done = 1'b0;
        compared++; if ({PSEL, PENABLE, PWRITE, int_valid} !== 4'b1010 || PWDATA !== 32'h9) begin mismatched++; $display("FAIL sc_wr_setup got=%b %h want=1010 9", {PSEL, PENABLE, PWRITE, int_valid}, PWDATA); end
        step; step;
        step; step; step;
        compared++; if (busy !== 1'b0 || wr_cnt !== w0 + 1) begin mismatched++; $display("FAIL sc_done got busy=%b wr=%0d want 0 %0d", busy, wr_cnt, w0 + 1); end
        int_done = 1'b1;
        step;
        int_done = 1'b0;
        step;
        compared++; if ({PSEL, busy} !== 2'b00) begin mismatched++; $display("FAIL sc_idle_done got=%b want=00", {PSEL, busy}); end
    endtask

    task automatic test_slverr;
        int w0;
        w0 = wr_cnt;
        PRDATA = 32'h7; PREADY = 1'b1; PSLVERR = 1'b1; int_ready = 1'b1; irq = 1'b1;
        step;
        irq = 1'b0;
        step; step;
        PSLVERR = 1'b0;
        compared++; if ({err, busy, PSEL, int_valid} !== 4'b1000) begin mismatched++; $display("FAIL err_read got=%b want=1000", {err, busy, PSEL, int_valid}); end
        step;
        compared++; if ({int_valid, busy} !== 2'b00) begin mismatched++; $display("FAIL err_no_valid got=%b want=00", {int_valid, busy}); end
        PRDATA = 32'h3; irq = 1'b1;
        step;
        irq = 1'b0;
        step; step;
        compared++; if (int_valid !== 1'b1 || int_id !== 4'd3) begin mismatched++; $display("FAIL err_good_dispatch got=%b id=%0d want=1 id=3", int_valid, int_id); end
        step;
        int_done = 1'b1;
        step;
        int_done = 1'b0;
        step; step;
        step; step; step;
        compared++; if ({err, busy} !== 2'b10 || wr_cnt !== w0 + 1) begin mismatched++; $display("FAIL err_sticky got=%b wr=%0d want=10 %0d", {err, busy}, wr_cnt, w0 + 1); end
        rst = 1'b1;
        step;
        rst = 1'b0;
        compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL err_rst_clear got=%b want=0", err); end
    endtask

    task automatic test_enable;
        int w0;
        w0 = wr_cnt;
        PRDATA = 32'h4; PREADY = 1'b1; int_ready = 1'b1; enable = 1'b1; irq = 1'b1;
        step;
        irq = 1'b0;
        step; step; step;
        enable = 1'b0; irq = 1'b1;
        step; step;
        int_done = 1'b1;
        step;
        int_done = 1'b0;
        compared++; if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PWDATA !== 32'h4) begin mismatched++; $display("FAIL en_wr_setup got=%b %h want=101 4", {PSEL, PENABLE, PWRITE}, PWDATA); end
        step; step;
        for (int i = 0; i < 6; i++) begin
            step;
            compared++; if (PSEL !== 1'b0) begin mismatched++; $display("FAIL en_no_read%0d got=%b want=0", i, PSEL); end
        end
        compared++; if (busy !== 1'b0 || wr_cnt !== w0 + 1) begin mismatched++; $display("FAIL en_completed got busy=%b wr=%0d want 0 %0d", busy, wr_cnt, w0 + 1); end
        enable = 1'b1;
        step;
        irq = 1'b0; PREADY = 1'b0;
        compared++; if ({PSEL, PENABLE} !== 2'b10) begin mismatched++; $display("FAIL en_resume got=%b want=10", {PSEL, PENABLE}); end
        step;
        compared++; if ({PSEL, PENABLE} !== 2'b11) begin mismatched++; $display("FAIL en_rd_access got=%b want=11", {PSEL, PENABLE}); end
        rst = 1'b1;
        step;
        rst = 1'b0; PREADY = 1'b1;
        compared++; if ({PSEL, PENABLE, PWRITE, int_valid, busy, err} !== 6'b0 || {PADDR, PWDATA, PSTRB} !== 68'h0 || {int_id, spurious_cnt} !== 12'h0) begin mismatched++; $display("FAIL en_mid_rst got=%b %h %h %h %h %h", {PSEL, PENABLE, PWRITE, int_valid, busy, err}, PADDR, PWDATA, PSTRB, int_id, spurious_cnt); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_spurious;
        test_wait_states;
        test_same_cycle;
        test_slverr;
        test_enable;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
